ct_mem_ctrl: RTL and testbench
==============================

Name: ct_mem_ctrl

Overview:
Sequencer between the AES core output and the 512x8 ciphertext store. It accepts 128-bit ciphertext blocks over a valid/ready handshake and serialises each block into 16 byte writes. It advances the 9-bit write pointer and arbitrates single-port memory access between the byte writer and an external byte read-out requester. It also reports fill level and wrap status to the host.

Parameters:
ADDR_W, 9, ciphertext store address width (depth 2^ADDR_W bytes)
DATA_W, 8, store word width in bits
BLK_BYTES, 16, bytes per ciphertext block (128/DATA_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous: pointer, count and wrap flag to 0; aborts burst
blk_valid  input  1  ciphertext block offered
blk_data  input  128  ciphertext block
blk_ready  output  1  controller can accept a block
rd_req  input  1  read-out request (level, held until granted)
rd_addr  input  ADDR_W  read-out byte address
rd_grant  output  1  read issued to memory this cycle
rd_valid  output  1  rd_data valid (one cycle after rd_grant)
rd_data  output  DATA_W  read-out byte
mem_en  output  1  memory access strobe
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, 1-cycle synchronous latency
wr_ptr  output  ADDR_W  next byte write address
blk_count  output  ADDR_W-3  completed blocks since reset/clear, saturating at 31
wrap_flag  output  1  sticky: pointer has wrapped 511->0

Behaviour:
- Reset values: blk_ready=1, rd_grant=0, rd_valid=0, rd_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ptr=0, blk_count=0, wrap_flag=0, FSM=IDLE.
- FSM states: IDLE, WRITE.
- IDLE: blk_ready=1. blk_valid&blk_ready at edge T latches blk_data into the shift register, clears beat counter, and moves to WRITE. blk_ready=0 from T+1.
- WRITE: each won cycle drives mem_en=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=current byte, then wr_ptr+1 and beat+1.
- After beat 15 is written: blk_count+1 (saturating) and return to IDLE. blk_ready=1 the following cycle. Minimum block period is 17 cycles.
- Default byte order: beat 0 = blk_data[127:120], beat 15 = blk_data[7:0].
- Arbitration is per cycle. In IDLE, rd_req is always granted. In WRITE, rd_req wins unless the previous cycle was a read grant, so reads and writes alternate under contention and neither side starves.
- Grant cycle: mem_en=1, mem_we=0, mem_addr=rd_addr, rd_grant=1. Next cycle: rd_valid=1, rd_data=mem_rdata.
- A stalled write beat holds its beat number and byte.
- Wrap: wr_ptr is modulo 2^ADDR_W. A write at 511 sets wr_ptr to 0 and sets wrap_flag. Blocks are 16-byte aligned, so a wrap only ever occurs on beat 15.
- clear: highest priority after rst. Zeroes wr_ptr, blk_count and wrap_flag, forces IDLE, and drops any partial burst (bytes already written stay in memory).
- clear does not suppress a rd_grant in the same cycle.
- blk_valid is ignored while blk_ready=0. blk_data is sampled only at acceptance.
- rst mid-burst: immediate return to reset values; the partial block is lost.

Optional Feature:
CT_LSB_FIRST_EN
- Defined: byte order reversed; beat 0 = blk_data[7:0], beat 15 = blk_data[127:120].
- Not defined: MSB-first order as above.
- All timing is identical in both modes.

Decomposition:
- Package ct_ctrl_pkg holds:
  - state enum (IDLE, WRITE)
  - BLK_BYTES and beat-counter width constants
  - CT_BLK_W = 128
  - BLK_CNT_MAX = 31
- Sub-module ct_wr_ptr: the ADDR_W-bit write-pointer counter with enable, clear and wrap pulse. Its wrap pulse feeds the sticky wrap_flag.

Test Plan:
- Single block 0x00112233_44556677_8899AABB_CCDDEEFF, no reads -> 16 writes to addr 0..15 carrying bytes 00,11,...,FF; blk_ready low 16 cycles; wr_ptr=16, blk_count=1.
- rd_req held with rd_addr=3 throughout a block write -> grants alternate with write beats; burst completes in 32 cycles; each rd_valid returns mem_rdata one cycle after its rd_grant.
- 32 back-to-back blocks -> wr_ptr wraps to 0 after beat 15 of block 31; wrap_flag=1; blk_count=31 saturated; 33rd block writes addr 0..15.
- clear asserted at beat 7 of a block -> next cycle IDLE, wr_ptr=0, blk_count=0, wrap_flag=0, blk_ready=1; no further writes.
- rst pulse asserted asynchronously mid-burst -> all outputs at reset values before the next clk edge; block offered after rst release is written from addr 0.
- CT_LSB_FIRST_EN build, block as in scenario 1 -> addr 0 holds FF, addr 15 holds 00.

Source files
------------

// File: rtl/ct_ctrl_pkg.sv
// Shared types and constants for the ciphertext store sequencer.
// Build option CT_LSB_FIRST_EN selects LSB-first byte serialisation.
package ct_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int CT_BLK_W     = 128;
  localparam int CT_BLK_BYTES = 16;
  localparam int CT_BEAT_W    = 4;
  localparam int BLK_CNT_MAX  = 31;

endpackage

// File: rtl/ct_wr_ptr.sv
// Byte write pointer for the ciphertext store.
// Counts modulo 2^ADDR_W and pulses wrap on the 511->0 step.
module ct_wr_ptr #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap
);

  assign wrap = en & ~clear & (ptr == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ct_mem_ctrl.sv
// Serialises 128-bit ciphertext blocks into a single-port byte store.
// Define CT_LSB_FIRST_EN to write blk_data[7:0] as beat 0.
module ct_mem_ctrl
  import ct_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int BLK_BYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                blk_valid,
  input  logic [127:0]        blk_data,
  output logic                blk_ready,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_grant,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic [ADDR_W-4:0]   blk_count,
  output logic                wrap_flag
);

  localparam int CNT_W = ADDR_W - 3;

  state_t                state_q;
  state_t                state_d;
  logic [CT_BLK_W-1:0]   sh_q;
  logic [CT_BEAT_W-1:0]  beat_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wrap_q;
  logic                  last_rd_q;
  logic                  rd_valid_q;
  logic                  rd_win;
  logic                  wr_win;
  logic                  accept;
  logic                  last_beat;
  logic                  wrap_pulse;
  logic [DATA_W-1:0]     cur_byte;

`ifdef CT_LSB_FIRST_EN
  assign cur_byte = sh_q[DATA_W-1:0];
`else
  assign cur_byte = sh_q[CT_BLK_W-1 -: DATA_W];
`endif

  // A read loses only right after its own grant, so both sides alternate.
  always_comb begin
    rd_win    = rd_req & ((state_q == IDLE) | ~last_rd_q);
    wr_win    = (state_q == WRITE) & ~rd_win & ~clear;
    accept    = (state_q == IDLE) & blk_valid & ~clear;
    last_beat = (beat_q == CT_BEAT_W'(BLK_BYTES - 1));
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = WRITE;
        WRITE:   if (wr_win && last_beat) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_win) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (wr_win) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_ptr;
      mem_wdata = cur_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q       <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      last_rd_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      last_rd_q  <= rd_win;
      rd_valid_q <= rd_win;
      if (clear) begin
        cnt_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        if (accept) begin
          sh_q   <= blk_data;
          beat_q <= '0;
        end else if (wr_win) begin
`ifdef CT_LSB_FIRST_EN
          sh_q <= sh_q >> DATA_W;
`else
          sh_q <= sh_q << DATA_W;
`endif
          beat_q <= beat_q + CT_BEAT_W'(1);
          if (last_beat && cnt_q != CNT_W'(BLK_CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        if (wrap_pulse) begin
          wrap_q <= 1'b1;
        end
      end
    end
  end

  ct_wr_ptr #(
    .ADDR_W(ADDR_W)
  ) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .en   (wr_win),
    .ptr  (wr_ptr),
    .wrap (wrap_pulse)
  );

  assign blk_ready = (state_q == IDLE);
  assign rd_grant  = rd_win;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? mem_rdata : '0;
  assign blk_count = cnt_q;
  assign wrap_flag = wrap_q;

endmodule

// File: tb/tb_ct_mem_ctrl.sv
// Directed bench for ct_mem_ctrl with a 512x8 synchronous store model.
// Byte-order expectations follow CT_LSB_FIRST_EN when defined.
module tb_ct_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data = '0;
  logic         blk_ready;
  logic         rd_req = 1'b0;
  logic [8:0]   rd_addr = '0;
  logic         rd_grant;
  logic         rd_valid;
  logic [7:0]   rd_data;
  logic         mem_en;
  logic         mem_we;
  logic [8:0]   mem_addr;
  logic [7:0]   mem_wdata;
  logic [7:0]   mem_rdata = '0;
  logic [8:0]   wr_ptr;
  logic [5:0]   blk_count;
  logic         wrap_flag;

  int vecs = 0;
  int errs = 0;

  logic [7:0] mem [0:511];
  logic [8:0] wlog_a [0:1023];
  logic [7:0] wlog_d [0:1023];
  int         wr_n = 0;

  localparam logic [127:0] PAT = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  ct_mem_ctrl dut (
    .clk(clk), .rst(rst), .clear(clear),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_ptr(wr_ptr), .blk_count(blk_count), .wrap_flag(wrap_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (wr_n < 1024) begin
        wlog_a[wr_n] = mem_addr;
        wlog_d[wr_n] = mem_wdata;
      end
      wr_n = wr_n + 1;
    end
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [45:0] outs();
    return {blk_ready, rd_grant, rd_valid, rd_data, mem_en, mem_we,
            mem_addr, mem_wdata, wr_ptr, blk_count, wrap_flag};
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
`ifdef CT_LSB_FIRST_EN
    return 8'((15 - i) * 8'h11);
`else
    return 8'(i * 8'h11);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!blk_ready && n < 200) begin
      tick();
      n++;
    end
    if (!blk_ready) begin
      errs++;
      $display("FAIL %s timeout: blk_ready=%0b required 1", nm, blk_ready);
    end
  endtask

  task automatic send_block(input logic [127:0] d);
    wait_ready("send");
    blk_valid = 1'b1;
    blk_data  = d;
    tick();
    blk_valid = 1'b0;
    blk_data  = '0;
  endtask

  task automatic test_reset();
    vecs++;
    if (outs() !== {1'b1, 45'b0}) begin
      errs++;
      $display("FAIL reset_outs got %h required %h", outs(), {1'b1, 45'b0});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n = 0;
    wr_n = 0;
    send_block(PAT);
    while (!blk_ready && n < 100) begin
      n++;
      tick();
    end
    vecs++;
    if (n !== 16) begin
      errs++;
      $display("FAIL single_busy got %0d cycles required 16", n);
    end
    vecs++;
    if (wr_n !== 16) begin
      errs++;
      $display("FAIL single_nwr got %0d required 16", wr_n);
    end
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (wlog_a[i] !== 9'(i) || wlog_d[i] !== exp_byte(i)) begin
        errs++;
        $display("FAIL single_beat%0d got %0d/%h required %0d/%h",
                 i, wlog_a[i], wlog_d[i], i, exp_byte(i));
      end
    end
    vecs++;
    if ({wr_ptr, blk_count, wrap_flag} !== {9'd16, 6'd1, 1'b0}) begin
      errs++;
      $display("FAIL single_state got ptr=%0d cnt=%0d wrap=%0b required 16/1/0",
               wr_ptr, blk_count, wrap_flag);
    end
  endtask

  task automatic test_reads();
    int n = 0;
    int gr = 0;
    int vld = 0;
    logic [7:0] b3;
    b3 = mem[3];
    wr_n = 0;
    send_block(128'hDEADBEEF_01020304_05060708_090A0B0C);
    rd_req  = 1'b1;
    rd_addr = 9'd3;
    #1;
    while (!blk_ready && n < 100) begin
      if (rd_grant) gr++;
      if (rd_grant === (n % 2 == 1)) begin
        vecs++;
        errs++;
        $display("FAIL reads_alt cycle %0d grant=%0b required %0b",
                 n, rd_grant, (n % 2 == 0));
      end
      if (rd_valid) begin
        vld++;
        vecs++;
        if (rd_data !== b3) begin
          errs++;
          $display("FAIL reads_data got %h required %h", rd_data, b3);
        end
      end
      n++;
      tick();
    end
    rd_req = 1'b0;
    vecs++;
    if (n !== 32 || gr !== 16 || vld !== 16 || wr_n !== 16) begin
      errs++;
      $display("FAIL reads_burst got n=%0d gr=%0d vld=%0d wr=%0d required 32/16/16/16",
               n, gr, vld, wr_n);
    end
    vecs++;
    if (b3 !== exp_byte(3)) begin
      errs++;
      $display("FAIL reads_mem3 got %h required %h", b3, exp_byte(3));
    end
    vecs++;
    if ({wr_ptr, blk_count} !== {9'd32, 6'd2}) begin
      errs++;
      $display("FAIL reads_state got ptr=%0d cnt=%0d required 32/2", wr_ptr, blk_count);
    end
  endtask

  task automatic test_clear();
    send_block(PAT);
    repeat (7) tick();
    vecs++;
    if (wr_ptr !== 9'd39) begin
      errs++;
      $display("FAIL clear_pre got ptr=%0d required 39", wr_ptr);
    end
    wr_n  = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vecs++;
    if ({blk_ready, wr_ptr, blk_count, wrap_flag} !== {1'b1, 9'd0, 6'd0, 1'b0}) begin
      errs++;
      $display("FAIL clear_post got rdy=%0b ptr=%0d cnt=%0d wrap=%0b required 1/0/0/0",
               blk_ready, wr_ptr, blk_count, wrap_flag);
    end
    repeat (5) tick();
    vecs++;
    if (wr_n !== 0) begin
      errs++;
      $display("FAIL clear_nowr got %0d writes required 0", wr_n);
    end
  endtask

  task automatic test_wrap();
    for (int b = 0; b < 31; b++) send_block({16{8'(b)}});
    wait_ready("wrap31");
    vecs++;
    if ({wr_ptr, blk_count, wrap_flag} !== {9'd496, 6'd31, 1'b0}) begin
      errs++;
      $display("FAIL wrap_31 got ptr=%0d cnt=%0d wrap=%0b required 496/31/0",
               wr_ptr, blk_count, wrap_flag);
    end
    send_block({16{8'h5A}});
    wait_ready("wrap32");
    vecs++;
    if ({wr_ptr, blk_count, wrap_flag} !== {9'd0, 6'd31, 1'b1}) begin
      errs++;
      $display("FAIL wrap_32 got ptr=%0d cnt=%0d wrap=%0b required 0/31/1",
               wr_ptr, blk_count, wrap_flag);
    end
    wr_n = 0;
    send_block(PAT);
    wait_ready("wrap33");
    vecs++;
    if (wr_n !== 16 || wlog_a[0] !== 9'd0 || wlog_a[15] !== 9'd15) begin
      errs++;
      $display("FAIL wrap_33 got n=%0d a0=%0d a15=%0d required 16/0/15",
               wr_n, wlog_a[0], wlog_a[15]);
    end
  endtask

  task automatic test_rst_mid();
    send_block(PAT);
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    vecs++;
    if (outs() !== {1'b1, 45'b0}) begin
      errs++;
      $display("FAIL rst_mid got %h required %h", outs(), {1'b1, 45'b0});
    end
    tick();
    rst = 1'b0;
    tick();
    wr_n = 0;
    send_block(PAT);
    wait_ready("rst_after");
    vecs++;
    if (wr_n !== 16 || wlog_a[0] !== 9'd0 || wlog_d[0] !== exp_byte(0)
        || wlog_a[15] !== 9'd15 || wlog_d[15] !== exp_byte(15)) begin
      errs++;
      $display("FAIL rst_after got n=%0d a0=%0d d0=%h a15=%0d d15=%h",
               wr_n, wlog_a[0], wlog_d[0], wlog_a[15], wlog_d[15]);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    #1;
    test_reset();
    test_single();
    test_reads();
    test_clear();
    test_wrap();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
